// File: rtl/diagnostics.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// diagnostics
// SPI-slave debug port that can halt the CPU, read/write main RAM while the
// CPU is halted, stream video RAM, and read/write the memory configuration.
//
// Ports
//   clk, reset          system clock, asynchronous active-low reset
//   halt                CPU halt request
//   spi_cs/clk/mosi     SPI slave inputs (mode 0, cs active-low), asynchronous
//   spi_miso            SPI slave output, changes on falling SCK
//   ram_address/datain  RAM address and write data
//   ram_dataout         RAM read data (valid 1 clk after ram_cs)
//   ram_cs, ram_we      RAM select / write strobe, single-cycle pulses
//   configuration       power-on configuration value
//   vram_read_address   video RAM read address, vram_output valid 1 clk later
//   vram_read_clock     video RAM read clock (equals clk)
//   config_byte         active memory configuration
//   vram_size           video RAM size in bytes
// -----------------------------------------------------------------------------
module diagnostics (
   input  logic        clk,
   input  logic        reset,
   output logic        halt,
   input  logic        spi_cs,
   input  logic        spi_clk,
   output logic        spi_miso,
   input  logic        spi_mosi,
   output logic [15:0] ram_address,
   input  logic [7:0]  ram_dataout,
   output logic [7:0]  ram_datain,
   output logic        ram_we,
   output logic        ram_cs,
   input  logic [4:0]  configuration,
   output logic [10:0] vram_read_address,
   input  logic [7:0]  vram_output,
   output logic        vram_read_clock,
   output logic [4:0]  config_byte,
   input  logic [10:0] vram_size
);

   localparam logic [7:0] CMD_HALT        = 8'h01;
   localparam logic [7:0] CMD_RUN         = 8'h02;
   localparam logic [7:0] CMD_READ_RAM    = 8'h03;
   localparam logic [7:0] CMD_WRITE_RAM   = 8'h04;
   localparam logic [7:0] CMD_READ_VRAM   = 8'h05;
   localparam logic [7:0] CMD_SET_CONFIG  = 8'h06;
   localparam logic [7:0] CMD_READ_CONFIG = 8'h07;

   typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR_HI, ST_ADDR_LO, ST_DATA} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cs_sync, sck_sync, mosi_sync;
   logic        sck_prev;
   logic        cs_act, sck_rise, sck_fall, byte_done;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift_in, rx_byte, tx_shift, tx_next, cmd;
   logic        fetch_p1, fetch_p2, fetch_vram, cfg_loaded;
   logic [10:0] vram_last;

   assign vram_read_clock = clk;
   assign spi_miso        = tx_shift[7];

   // synchronizer boundary: SPI pins into the clk domain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs_sync   <= 2'b11;
         sck_sync  <= 2'b00;
         mosi_sync <= 2'b00;
         sck_prev  <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[0], spi_cs};
         sck_sync  <= {sck_sync[0], spi_clk};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         sck_prev  <= sck_sync[1];
      end
   end

   assign cs_act    = ~cs_sync[1];
   assign sck_rise  = cs_act &  sck_sync[1] & ~sck_prev;
   assign sck_fall  = cs_act & ~sck_sync[1] &  sck_prev;
   assign byte_done = sck_rise & (bit_cnt == 3'd7);
   assign rx_byte   = {shift_in[6:0], mosi_sync[1]};
   assign vram_last = vram_size - 11'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!cs_act) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    state_d = ST_CMD;
            ST_CMD:     if (byte_done)
                           state_d = (rx_byte == CMD_READ_RAM || rx_byte == CMD_WRITE_RAM)
                                     ? ST_ADDR_HI : ST_DATA;
            ST_ADDR_HI: if (byte_done) state_d = ST_ADDR_LO;
            ST_ADDR_LO: if (byte_done) state_d = ST_DATA;
            default:    state_d = state_q;
         endcase
      end
   end

   // control, strobes and addresses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         halt              <= 1'b0;
         ram_cs            <= 1'b0;
         ram_we            <= 1'b0;
         ram_address       <= 16'h0000;
         ram_datain        <= 8'h00;
         vram_read_address <= 11'd0;
         config_byte       <= 5'd0;
         cfg_loaded        <= 1'b0;
         bit_cnt           <= 3'd0;
         tx_shift          <= 8'h00;
         cmd               <= 8'h00;
         fetch_p1          <= 1'b0;
         fetch_p2          <= 1'b0;
         fetch_vram        <= 1'b0;
      end else begin
         ram_cs   <= 1'b0;
         ram_we   <= 1'b0;
         fetch_p1 <= 1'b0;
         fetch_p2 <= fetch_p1;
         if (!cfg_loaded) begin
            config_byte <= configuration;
            cfg_loaded  <= 1'b1;
         end
         // the write strobe is issued at the current address; step afterwards
         if (ram_we) ram_address <= ram_address + 16'd1;
         if (!cs_act) begin
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            cmd      <= 8'h00;
         end else begin
            if (sck_rise) bit_cnt <= bit_cnt + 3'd1;
            // byte boundary falling edge loads the next byte, else shift
            if (sck_fall) tx_shift <= (bit_cnt == 3'd0) ? tx_next : {tx_shift[6:0], 1'b0};
            if (byte_done) begin
               case (state_q)
                  ST_CMD: begin
                     cmd <= rx_byte;
                     if (rx_byte == CMD_HALT) halt <= 1'b1;
                     if (rx_byte == CMD_RUN)  halt <= 1'b0;
                     if (rx_byte == CMD_READ_VRAM) begin
                        vram_read_address <= 11'd0;
                        fetch_vram        <= 1'b1;
                        fetch_p1          <= (vram_size != 11'd0);
                     end
                  end
                  ST_ADDR_HI: ram_address[15:8] <= rx_byte;
                  ST_ADDR_LO: begin
                     ram_address[7:0] <= rx_byte;
                     if (cmd == CMD_READ_RAM && halt) begin
                        ram_cs     <= 1'b1;
                        fetch_p1   <= 1'b1;
                        fetch_vram <= 1'b0;
                     end
                  end
                  ST_DATA: begin
                     if (cmd == CMD_READ_RAM && halt) begin
                        ram_address <= ram_address + 16'd1;
                        ram_cs      <= 1'b1;
                        fetch_p1    <= 1'b1;
                        fetch_vram  <= 1'b0;
                     end
                     if (cmd == CMD_WRITE_RAM && halt) begin
                        ram_datain <= rx_byte;
                        ram_cs     <= 1'b1;
                        ram_we     <= 1'b1;
                     end
                     if (cmd == CMD_READ_VRAM && vram_size != 11'd0) begin
                        vram_read_address <= (vram_read_address >= vram_last)
                                             ? 11'd0 : vram_read_address + 11'd1;
                        fetch_vram        <= 1'b1;
                        fetch_p1          <= 1'b1;
                     end
                     if (cmd == CMD_SET_CONFIG) config_byte <= rx_byte[4:0];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // receive shifter and next transmit byte (data only)
   always_ff @(posedge clk) begin
      if (sck_rise) shift_in <= rx_byte;
      if (byte_done) begin
         tx_next <= 8'h00;
         if ((state_q == ST_CMD && rx_byte == CMD_READ_CONFIG) ||
             (state_q == ST_DATA && cmd == CMD_READ_CONFIG))
            tx_next <= {3'b000, config_byte};
      end else if (fetch_p2) begin
         tx_next <= fetch_vram ? vram_output : ram_dataout;
      end
   end

endmodule

// File: tb/tb_diagnostics.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_diagnostics
// Directed bench for diagnostics: drives SPI transactions byte by byte, models
// RAM and VRAM, logs every RAM write strobe and compares against hand values.
// -----------------------------------------------------------------------------
module tb_diagnostics;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        halt;
   logic        spi_cs, spi_clk, spi_miso, spi_mosi;
   logic [15:0] ram_address;
   logic [7:0]  ram_dataout = 8'h00;
   logic [7:0]  ram_datain;
   logic        ram_we, ram_cs;
   logic [4:0]  configuration;
   logic [10:0] vram_read_address;
   logic [7:0]  vram_output = 8'h00;
   logic        vram_read_clock;
   logic [4:0]  config_byte;
   logic [10:0] vram_size;

   always #5 clk = ~clk;

   diagnostics dut (
      .clk(clk), .reset(rst_n), .halt(halt),
      .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_miso(spi_miso), .spi_mosi(spi_mosi),
      .ram_address(ram_address), .ram_dataout(ram_dataout), .ram_datain(ram_datain),
      .ram_we(ram_we), .ram_cs(ram_cs), .configuration(configuration),
      .vram_read_address(vram_read_address), .vram_output(vram_output),
      .vram_read_clock(vram_read_clock), .config_byte(config_byte), .vram_size(vram_size)
   );

   // memory models
   logic [7:0] mem  [0:65535];
   logic [7:0] vram [0:2047];

   always @(posedge clk) begin
      if (ram_cs && ram_we)  mem[ram_address] <= ram_datain;
      if (ram_cs && !ram_we) ram_dataout <= mem[ram_address];
   end

   always @(posedge vram_read_clock) vram_output <= vram[vram_read_address];

   // write-strobe logger
   logic [15:0] wr_addr [0:63];
   logic [7:0]  wr_data [0:63];
   int wr_cnt = 0, cs_cnt = 0, we_bad = 0;
   logic we_prev = 1'b0;

   always @(posedge clk) begin
      if (ram_we) begin
         if (wr_cnt < 64) begin
            wr_addr[wr_cnt] = ram_address;
            wr_data[wr_cnt] = ram_datain;
         end
         wr_cnt++;
         if (!ram_cs || we_prev) we_bad++;
      end
      if (ram_cs) cs_cnt++;
      we_prev = ram_we;
   end

   int n_cmp = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] rx_buf [0:7];

   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = tx[7-i];
         repeat (5) @(negedge clk);
         rx[7-i] = spi_miso;
         spi_clk = 1'b1;
         repeat (5) @(negedge clk);
         spi_clk = 1'b0;
      end
   endtask

   // n bytes taken MSB-first from the packed vector
   task automatic txn(input int n, input logic [63:0] bytes);
      logic [7:0] r;
      spi_cs = 1'b0;
      repeat (4) @(negedge clk);
      for (int k = 0; k < n; k++) begin
         spi_xfer(bytes[63-8*k -: 8], 8, r);
         rx_buf[k] = r;
      end
      repeat (4) @(negedge clk);
      spi_cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   int base_wr, base_cs;
   logic [7:0] dummy;

   initial begin
      rst_n = 1'b0; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
      configuration = 5'h0A; vram_size = 11'd3;
      vram[0] = 8'h11; vram[1] = 8'h22; vram[2] = 8'h33; vram[3] = 8'h44;
      repeat (3) @(negedge clk);
      check("rst_halt", halt, 0);
      check("rst_ram_cs", ram_cs, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_address, 0);
      check("rst_ram_datain", ram_datain, 0);
      check("rst_vram_addr", vram_read_address, 0);
      check("rst_miso", spi_miso, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("cfg_load", config_byte, 5'h0A);
      check("post_rst_halt", halt, 0);
      check("post_rst_strobes", {ram_cs, ram_we}, 0);
      configuration = 5'h03;
      repeat (3) @(negedge clk);
      check("cfg_hold", config_byte, 5'h0A);

      // HALT / RUN
      txn(1, {8'h01, 56'h0});
      check("halt_set", halt, 1);
      check("halt_miso", rx_buf[0], 8'h00);
      txn(1, {8'h02, 56'h0});
      check("run_clr", halt, 0);
      txn(1, {8'h01, 56'h0});
      check("halt_again", halt, 1);

      // halted write then read back
      base_wr = wr_cnt;
      txn(5, {8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 24'h0});
      check("wr_count", wr_cnt - base_wr, 2);
      check("wr0_addr", wr_addr[base_wr], 16'h1234);
      check("wr0_data", wr_data[base_wr], 8'hAB);
      check("wr1_addr", wr_addr[base_wr+1], 16'h1235);
      check("wr1_data", wr_data[base_wr+1], 8'hCD);
      check("we_pulse_shape", we_bad, 0);
      txn(5, {8'h03, 8'h12, 8'h34, 8'h00, 8'h00, 24'h0});
      check("rd_addr_miso", {rx_buf[0], rx_buf[1], rx_buf[2]}, 24'h0);
      check("rd_byte0", rx_buf[3], 8'hAB);
      check("rd_byte1", rx_buf[4], 8'hCD);

      // running: RAM access blocked
      txn(1, {8'h02, 56'h0});
      base_wr = wr_cnt; base_cs = cs_cnt;
      txn(4, {8'h04, 8'h12, 8'h34, 8'h55, 32'h0});
      txn(4, {8'h03, 8'h12, 8'h34, 8'h00, 32'h0});
      check("run_no_write", wr_cnt - base_wr, 0);
      check("run_no_cs", cs_cnt - base_cs, 0);
      check("run_read_zero", rx_buf[3], 8'h00);
      check("run_mem_kept", mem[16'h1234], 8'hAB);

      // VRAM stream with wrap at vram_size
      txn(5, {8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 24'h0});
      check("vram0", rx_buf[1], 8'h11);
      check("vram1", rx_buf[2], 8'h22);
      check("vram2", rx_buf[3], 8'h33);
      check("vram_wrap", rx_buf[4], 8'h11);
      vram_size = 11'd0;
      txn(2, {8'h05, 8'h00, 48'h0});
      check("vram_size0", rx_buf[1], 8'h00);
      vram_size = 11'd3;

      // configuration
      txn(2, {8'h06, 8'h1F, 48'h0});
      check("set_cfg", config_byte, 5'h1F);
      txn(2, {8'h07, 8'h00, 48'h0});
      check("read_cfg", rx_buf[1], 8'h1F);

      // cs raised mid data byte
      txn(1, {8'h01, 56'h0});
      base_wr = wr_cnt;
      spi_cs = 1'b0;
      repeat (4) @(negedge clk);
      spi_xfer(8'h04, 8, dummy);
      spi_xfer(8'h12, 8, dummy);
      spi_xfer(8'h34, 8, dummy);
      spi_xfer(8'hEE, 4, dummy);
      spi_cs = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_no_write", wr_cnt - base_wr, 0);
      check("abort_halt_kept", halt, 1);
      txn(2, {8'h07, 8'h00, 48'h0});
      check("abort_bitcnt_clr", rx_buf[1], 8'h1F);

      // address wrap 0xFFFF -> 0x0000
      base_wr = wr_cnt;
      txn(5, {8'h04, 8'hFF, 8'hFF, 8'h5A, 8'h5B, 24'h0});
      check("wrap_count", wr_cnt - base_wr, 2);
      check("wrap_addr0", wr_addr[base_wr], 16'hFFFF);
      check("wrap_addr1", wr_addr[base_wr+1], 16'h0000);
      check("wrap_data1", wr_data[base_wr+1], 8'h5B);
      txn(5, {8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00, 24'h0});
      check("wrap_rd0", rx_buf[3], 8'h5A);
      check("wrap_rd1", rx_buf[4], 8'h5B);

      // reset asserted mid-transaction
      base_wr = wr_cnt;
      spi_cs = 1'b0;
      repeat (4) @(negedge clk);
      spi_xfer(8'h04, 8, dummy);
      spi_xfer(8'h12, 8, dummy);
      spi_xfer(8'h34, 8, dummy);
      spi_xfer(8'h77, 5, dummy);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_halt", halt, 0);
      check("mid_rst_addr", ram_address, 0);
      check("mid_rst_miso", spi_miso, 0);
      spi_cs = 1'b1; spi_clk = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("mid_rst_no_write", wr_cnt - base_wr, 0);
      check("mid_rst_cfg_reload", config_byte, 5'h03);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
